// File: rtl/servo_cmd_scheduler_if.sv
// Command handshake from the line-following control logic into the servo scheduler.
// The master offers a left/right pair with cmd_valid; the slave accepts it when cmd_ready is high.
interface servo_cmd_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_L;
  logic [7:0] cmd_R;

  modport master (
    output cmd_valid,
    output cmd_L,
    output cmd_R,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_L,
    input  cmd_R,
    output cmd_ready
  );
endinterface

// File: rtl/servo_cmd_scheduler.sv
// Frame-synchronous servo command scheduler: one-deep command buffer, frame-aligned apply,
// watchdog failsafe to neutral. Define SERVO_SLEW_EN to limit per-frame servo movement to STEP.
module servo_cmd_scheduler #(
  parameter int FRAME_CYCLES   = 1_000_000,
  parameter int NEUTRAL        = 75,
  parameter int STEP           = 4,
  parameter int TIMEOUT_FRAMES = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  servo_cmd_scheduler_if.slave cmd,
  output logic [7:0]           servo_L,
  output logic [7:0]           servo_R,
  output logic                 frame_tick,
  output logic                 failsafe
);

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // A step of 255 reaches any target in one frame, so the unlimited build shares the step datapath.
  localparam int                EFF_STEP  = SLEW_EN ? STEP : 255;
  localparam logic [8:0]        STEP9     = 9'(EFF_STEP);
  localparam logic [7:0]        STEP8     = 8'(EFF_STEP);
  localparam logic [7:0]        NEUTRAL8  = 8'(NEUTRAL);
  localparam int                FCNT_W    = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_CYCLES - 1);
  localparam int                WD_W      = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_FRAMES);
  localparam bit                WD_EN     = (TIMEOUT_FRAMES != 0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FAILSAFE = 2'd2
  } state_t;

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              frame_tick_q, frame_tick_d;
  logic              pend_v_q, pend_v_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc;
  state_t            state_q, state_d;

  logic              tick;
  logic              xfer;
  logic              consume;
  logic              timeout;

  logic [7:0]        cmd_val   [2];
  logic [7:0]        servo_val [2];

  assign cmd_val[0] = cmd.cmd_L;
  assign cmd_val[1] = cmd.cmd_R;

  // Frame phase and the one-cycle tick that marks the wrap edge.
  always_comb begin
    tick         = (fcnt_q == FCNT_LAST);
    fcnt_d       = tick ? '0 : fcnt_q + FCNT_W'(1);
    frame_tick_d = tick;
  end

  // A buffered command is consumed on the tick; the buffer reopens in the next cycle.
  always_comb begin
    xfer     = cmd.cmd_valid && !pend_v_q;
    consume  = tick && pend_v_q;
    pend_v_d = pend_v_q;
    if (xfer) begin
      pend_v_d = 1'b1;
    end else if (consume) begin
      pend_v_d = 1'b0;
    end
  end

  always_comb begin
    wd_inc  = wd_q + WD_W'(1);
    timeout = WD_EN && tick && !pend_v_q && (state_q == ST_RUN) && (wd_inc == WD_LIMIT);
    wd_d    = wd_q;
    if (consume) begin
      wd_d = '0;
    end else if (WD_EN && tick && (state_q == ST_RUN)) begin
      wd_d = wd_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A command consumed on the same tick as a timeout keeps the block running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (consume) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (consume) begin
          state_d = ST_RUN;
        end else if (timeout) begin
          state_d = ST_FAILSAFE;
        end
      end
      ST_FAILSAFE: begin
        if (consume) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    failsafe      = (state_q == ST_FAILSAFE);
    cmd.cmd_ready = !pend_v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q       <= '0;
      frame_tick_q <= 1'b0;
      pend_v_q     <= 1'b0;
      wd_q         <= '0;
    end else begin
      fcnt_q       <= fcnt_d;
      frame_tick_q <= frame_tick_d;
      pend_v_q     <= pend_v_d;
      wd_q         <= wd_d;
    end
  end

  // Index 0 is the left servo, index 1 the right servo.
  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic [7:0]        pend_q, pend_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        servo_q, servo_d;
    logic signed [8:0] diff;
    logic [8:0]        mag;

    always_comb begin
      pend_d   = xfer ? cmd_val[gi] : pend_q;
      target_d = target_q;
      if (consume) begin
        target_d = pend_q;
      end else if (timeout) begin
        target_d = NEUTRAL8;
      end
      // Distance is taken against the target as it stands after this tick's update.
      diff    = $signed({1'b0, target_d}) - $signed({1'b0, servo_q});
      mag     = diff[8] ? $unsigned(-diff) : $unsigned(diff);
      servo_d = servo_q;
      if (tick) begin
        if (mag <= STEP9) begin
          servo_d = target_d;
        end else if (diff[8]) begin
          servo_d = servo_q - STEP8;
        end else begin
          servo_d = servo_q + STEP8;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q   <= '0;
        target_q <= NEUTRAL8;
        servo_q  <= NEUTRAL8;
      end else begin
        pend_q   <= pend_d;
        target_q <= target_d;
        servo_q  <= servo_d;
      end
    end

    assign servo_val[gi] = servo_q;
  end

  assign servo_L    = servo_val[0];
  assign servo_R    = servo_val[1];
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Randomised bench for servo_cmd_scheduler: a frame-level reference model is compared against
// the DUT every cycle, with a few hand-computed expectations pinning the model.
`timescale 1ns/1ps
module tb_servo_cmd_scheduler;
  localparam int FC  = 100;
  localparam int NEU = 75;
  localparam int STP = 4;
  localparam int TMO = 3;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] servo_L;
  logic [7:0] servo_R;
  logic       frame_tick;
  logic       failsafe;

  servo_cmd_scheduler_if cmd_if();

  servo_cmd_scheduler #(
    .FRAME_CYCLES  (FC),
    .NEUTRAL       (NEU),
    .STEP          (STP),
    .TIMEOUT_FRAMES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .servo_L   (servo_L),
    .servo_R   (servo_R),
    .frame_tick(frame_tick),
    .failsafe  (failsafe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  // Reference model state: frame phase, pending slot, targets, servo values, mode.
  int m_phase, m_pend_l, m_pend_r, m_tgt_l, m_tgt_r, m_srv_l, m_srv_r, m_quiet;
  int m_mode;  // 0 idle, 1 run, 2 failsafe
  bit m_pend_v, m_tick;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int approach(input int s, input int t);
    int d;
    if (!SLEW) return t;
    d = t - s;
    if (d <= STP && d >= -STP) return t;
    return (d > 0) ? s + STP : s - STP;
  endfunction

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    bit t, x;
    if (rst) begin
      m_phase = 0; m_pend_v = 0; m_pend_l = 0; m_pend_r = 0;
      m_tgt_l = NEU; m_tgt_r = NEU; m_srv_l = NEU; m_srv_r = NEU;
      m_quiet = 0; m_mode = 0; m_tick = 0;
    end else begin
      t = (m_phase == FC - 1);
      m_phase = t ? 0 : m_phase + 1;
      x = cmd_if.cmd_valid && !m_pend_v;
      if (t) begin
        if (m_pend_v) begin
          m_tgt_l = m_pend_l; m_tgt_r = m_pend_r;
          m_pend_v = 0; m_mode = 1; m_quiet = 0;
        end else if (m_mode == 1) begin
          m_quiet++;
          if (TMO != 0 && m_quiet >= TMO) begin
            m_tgt_l = NEU; m_tgt_r = NEU; m_mode = 2;
          end
        end
        m_srv_l = approach(m_srv_l, m_tgt_l);
        m_srv_r = approach(m_srv_r, m_tgt_r);
      end
      if (x) begin
        m_pend_l = int'(cmd_if.cmd_L); m_pend_r = int'(cmd_if.cmd_R); m_pend_v = 1;
      end
      m_tick = t;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("frame_tick", int'(frame_tick), int'(m_tick));
      chk("servo_L", int'(servo_L), m_srv_l);
      chk("servo_R", int'(servo_R), m_srv_r);
      chk("failsafe", int'(failsafe), (m_mode == 2) ? 1 : 0);
      chk("cmd_ready", int'(cmd_if.cmd_ready), m_pend_v ? 0 : 1);
    end
  end

  // Returns at the negedge on which the next frame_tick is visible.
  task automatic wait_tick(output int at);
    at = -1;
    for (int n = 0; n < 3 * FC; n++) begin
      @(negedge clk);
      if (frame_tick) begin
        at = cyc;
        return;
      end
    end
    chk("wait_tick_timeout", 0, 1);
  endtask

  // Holds the command until it is accepted; starts and ends on a negedge.
  task automatic send(input int l, input int r);
    bit rdy;
    int n;
    n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_L     = 8'(l);
    cmd_if.cmd_R     = 8'(r);
    forever begin
      rdy = cmd_if.cmd_ready;
      @(negedge clk);
      n++;
      if (rdy) break;
      if (n > 3 * FC) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    cmd_if.cmd_valid = 1'b0;
    $display("cmd L=%0d R=%0d accepted cyc=%0d", l, r, cyc);
  endtask

  function automatic int rnd8();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int at;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_L     = 8'd0;
    cmd_if.cmd_R     = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_servo_L", int'(servo_L), 75);
    chk("rst_servo_R", int'(servo_R), 75);
    chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
    chk("rst_failsafe", int'(failsafe), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    rst = 1'b0;

    // Idle frames: ticks at 100/200/300, no watchdog while idle.
    wait_tick(at); chk("tick1_cycle", at, 100);
    wait_tick(at); chk("tick2_cycle", at, 200);
    wait_tick(at); chk("tick3_cycle", at, 300);
    chk("idle_servo_L", int'(servo_L), 75);
    chk("idle_failsafe", int'(failsafe), 0);

    // Slewing toward (90,60), refreshing the command every frame.
    repeat (10) @(negedge clk);
    send(90, 60);
    chk("pend_ready_low", int'(cmd_if.cmd_ready), 0);
    wait_tick(at);
    chk("step1_L", int'(servo_L), SLEW ? 79 : 90);
    chk("step1_R", int'(servo_R), SLEW ? 71 : 60);
    repeat (3) begin
      send(90, 60);
      wait_tick(at);
    end
    chk("reach_L", int'(servo_L), 90);
    chk("reach_R", int'(servo_R), 60);

    // Three quiet frames trip the watchdog.
    wait_tick(at); chk("quiet1_failsafe", int'(failsafe), 0);
    wait_tick(at); chk("quiet2_failsafe", int'(failsafe), 0);
    wait_tick(at);
    chk("timeout_failsafe", int'(failsafe), 1);
    chk("timeout_L", int'(servo_L), SLEW ? 86 : 75);
    chk("timeout_R", int'(servo_R), SLEW ? 64 : 75);
    repeat (3) wait_tick(at);
    chk("neutral_L", int'(servo_L), 75);
    chk("neutral_R", int'(servo_R), 75);
    send(100, 100);
    chk("fs_hold", int'(failsafe), 1);
    wait_tick(at);
    chk("recover_failsafe", int'(failsafe), 0);
    chk("recover_L", int'(servo_L), SLEW ? 79 : 100);

    // Second command is held off until the tick edge, then applied a frame later.
    send(120, 130);
    send(140, 150);
    chk("b2b_ready_low", int'(cmd_if.cmd_ready), 0);
    chk("b2b_first_L", int'(servo_L), SLEW ? 83 : 120);
    chk("b2b_first_R", int'(servo_R), SLEW ? 83 : 130);
    wait_tick(at);
    chk("b2b_second_L", int'(servo_L), SLEW ? 87 : 140);
    chk("b2b_second_R", int'(servo_R), SLEW ? 87 : 150);

    // Walk to (253,2), then command the rails: no wrap-around.
    for (int k = 0; k < 80; k++) begin
      if (m_srv_l == 253 && m_srv_r == 2) break;
      send(253, 2);
      wait_tick(at);
    end
    chk("pre_edge_L", int'(servo_L), 253);
    chk("pre_edge_R", int'(servo_R), 2);
    send(255, 0);
    wait_tick(at);
    chk("edge_L", int'(servo_L), 255);
    chk("edge_R", int'(servo_R), 0);

    // Reset mid-frame with a command pending.
    send(10, 240);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_servo_L", int'(servo_L), 75);
    chk("midrst_servo_R", int'(servo_R), 75);
    chk("midrst_ready", int'(cmd_if.cmd_ready), 1);
    rst = 1'b0;
    wait_tick(at);
    chk("midrst_tick_cycle", at, 100);
    chk("midrst_failsafe", int'(failsafe), 0);

    // Random traffic with gaps long enough to time out, plus occasional resets.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      send(rnd8(), rnd8());
    end
    repeat (5 * FC) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
